// File: rtl/stage5.sv
// stage5 -- writeback pipeline register.
// Captures the memory-stage slot, extracts and extends load data,
// detects misaligned loads, qualifies the register-file write enables
// and counts retired non-trapping instructions.
module stage5 #(
  parameter int INSTRET_EN = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        valid_mem,
  input  logic [4:0]  rd_mem,
  input  logic [63:0] op_mem,
  input  logic        we_rd_mem,
  input  logic        reg_type_mem,
  input  logic        trap_mem,
  input  logic        load_mem,
  input  logic [1:0]  load_size,
  input  logic        load_unsigned,
  input  logic [2:0]  load_offset,
  input  logic [63:0] mem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  rd_wb,
  output logic [63:0] wb_data,
  output logic        we_int_wb,
  output logic        we_fp_wb,
  output logic        trap_wb,
  output logic        misalign_wb,
  output logic        valid_wb,
  output logic [63:0] instret
);

  // The counter logic is still built when disabled, but its increment
  // is gated off so the register never leaves zero.
  localparam logic INSTRET_ON = (INSTRET_EN != 0);

  logic        size_misalign_s;
  logic        slot_misalign_s;
  logic        slot_trap_s;
  logic [63:0] shifted_s;
  logic        sign_bit_s;
  logic        ext_bit_s;
  logic [63:0] load_val_s;

  logic [4:0]  rd_d,       rd_q;
  logic [63:0] data_d,     data_q;
  logic        we_int_d,   we_int_q;
  logic        we_fp_d,    we_fp_q;
  logic        trap_d,     trap_q;
  logic        misalign_d, misalign_q;
  logic        valid_d,    valid_q;
  logic [63:0] instret_d,  instret_q;

  // Alignment check: the offset must be a multiple of the access size.
  always_comb begin
    size_misalign_s = 1'b0;
    case (load_size)
      2'b00:   size_misalign_s = 1'b0;
      2'b01:   size_misalign_s = load_offset[0];
      2'b10:   size_misalign_s = (load_offset[1:0] != 2'b00);
      2'b11:   size_misalign_s = (load_offset != 3'b000);
      default: size_misalign_s = 1'b0;
    endcase
  end

  // A misaligned load is treated as a trap; bubbles never trap.
  always_comb begin
    slot_misalign_s = valid_mem & load_mem & size_misalign_s;
    slot_trap_s     = valid_mem & (trap_mem | slot_misalign_s);
  end

  // Bring the addressed byte down to bit 0 and pick the sign bit of the access.
  always_comb begin
    shifted_s  = mem_rdata >> {load_offset, 3'b000};
    sign_bit_s = 1'b0;
    case (load_size)
      2'b00:   sign_bit_s = shifted_s[7];
      2'b01:   sign_bit_s = shifted_s[15];
      2'b10:   sign_bit_s = shifted_s[31];
      2'b11:   sign_bit_s = shifted_s[63];
      default: sign_bit_s = 1'b0;
    endcase
    // FP loads ignore load_unsigned and never sign-extend.
    if (reg_type_mem || load_unsigned) begin
      ext_bit_s = 1'b0;
    end else begin
      ext_bit_s = sign_bit_s;
    end
  end

  // Width selection with sign/zero extension; FP words are NaN-boxed.
  always_comb begin
    load_val_s = shifted_s;
    case (load_size)
      2'b00: load_val_s = {{56{ext_bit_s}}, shifted_s[7:0]};
      2'b01: load_val_s = {{48{ext_bit_s}}, shifted_s[15:0]};
      2'b10: begin
        if (reg_type_mem) begin
          load_val_s = {32'hFFFF_FFFF, shifted_s[31:0]};
        end else begin
          load_val_s = {{32{ext_bit_s}}, shifted_s[31:0]};
        end
      end
      2'b11:   load_val_s = shifted_s;
      default: load_val_s = shifted_s;
    endcase
  end

  // Next-state selection: flush beats stall, stall beats capture.
  always_comb begin
    rd_d       = rd_q;
    data_d     = data_q;
    we_int_d   = we_int_q;
    we_fp_d    = we_fp_q;
    trap_d     = trap_q;
    misalign_d = misalign_q;
    valid_d    = valid_q;
    instret_d  = instret_q;
    if (flush) begin
      // Squash: only the qualifiers are cleared, payload is don't-care.
      we_int_d   = 1'b0;
      we_fp_d    = 1'b0;
      trap_d     = 1'b0;
      misalign_d = 1'b0;
      valid_d    = 1'b0;
    end else if (stall) begin
      // Hold everything, including the retire count.
      valid_d    = valid_q;
      instret_d  = instret_q;
    end else begin
      rd_d       = rd_mem;
      data_d     = load_mem ? load_val_s : op_mem;
      valid_d    = valid_mem;
      trap_d     = slot_trap_s;
      misalign_d = slot_misalign_s;
      we_int_d   = valid_mem & we_rd_mem & ~reg_type_mem & ~slot_trap_s
                   & (rd_mem != 5'd0);
      we_fp_d    = valid_mem & we_rd_mem & reg_type_mem & ~slot_trap_s;
      if (valid_mem && !slot_trap_s && INSTRET_ON) begin
        instret_d = instret_q + 64'd1;
      end else begin
        instret_d = instret_q;
      end
    end
  end

  // Writeback register with asynchronous clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_q       <= 5'd0;
      data_q     <= 64'd0;
      we_int_q   <= 1'b0;
      we_fp_q    <= 1'b0;
      trap_q     <= 1'b0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
      instret_q  <= 64'd0;
    end else begin
      rd_q       <= rd_d;
      data_q     <= data_d;
      we_int_q   <= we_int_d;
      we_fp_q    <= we_fp_d;
      trap_q     <= trap_d;
      misalign_q <= misalign_d;
      valid_q    <= valid_d;
      instret_q  <= instret_d;
    end
  end

  assign rd_wb       = rd_q;
  assign wb_data     = data_q;
  assign we_int_wb   = we_int_q;
  assign we_fp_wb    = we_fp_q;
  assign trap_wb     = trap_q;
  assign misalign_wb = misalign_q;
  assign valid_wb    = valid_q;
  assign instret     = instret_q;

endmodule
